// File: rtl/turn_signal_ctrl.sv
// Turn-signal / hazard controller: level stalk and hazard modes, comfort-tap blinking,
// programmable cadence and a registered click pulse on every lamp toggle.
module turn_signal_ctrl #(
    parameter int unsigned BLINK_HALF = 25_000_000,
    parameter int unsigned TAP_BLINKS = 3,
    parameter int unsigned CNT_W      = $clog2(BLINK_HALF),
    parameter int unsigned TAP_W      = $clog2(TAP_BLINKS + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       left,
    input  logic       right,
    input  logic       hazard,
    input  logic       tap_left,
    input  logic       tap_right,
    output logic       left_lamp,
    output logic       right_lamp,
    output logic       click,
    output logic [2:0] mode
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StLeft   = 3'd1,
        StRight  = 3'd2,
        StHazard = 3'd3,
        StTapL   = 3'd5,
        StTapR   = 3'd6
    } state_e;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(BLINK_HALF - 1);
    localparam logic [TAP_W-1:0] BcntEnd = TAP_W'(TAP_BLINKS);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TAP_W-1:0] bcnt_q, bcnt_d;
    logic             phase_q, phase_d;
    logic             left_lamp_q, left_lamp_d;
    logic             right_lamp_q, right_lamp_d;
    logic             click_q, click_d;

    logic             rearm;
    logic             restart;
    logic             toggle;
    logic             in_tap;
    logic             idle_q;

    assign idle_q = (state_q == StIdle);
    assign in_tap = (state_q == StTapL) || (state_q == StTapR);

    always_comb begin
        state_d      = state_q;
        rearm        = 1'b0;
        restart      = 1'b0;
        toggle       = 1'b0;
        cnt_d        = '0;
        phase_d      = 1'b0;
        bcnt_d       = '0;
        left_lamp_d  = 1'b0;
        right_lamp_d = 1'b0;
        click_d      = 1'b0;

        // Mode selection, highest priority first.
        if (hazard) begin
            state_d = StHazard;
        end else if (left && right) begin
            state_d = StIdle;
        end else if (left) begin
            state_d = StLeft;
        end else if (right) begin
            state_d = StRight;
        end else if (tap_left && !tap_right && (idle_q || in_tap)) begin
            state_d = StTapL;
            rearm   = 1'b1;
        end else if (tap_right && !tap_left && (idle_q || in_tap)) begin
            state_d = StTapR;
            rearm   = 1'b1;
        end else if (!idle_q && !in_tap) begin
            state_d = StIdle;
        end

        restart = (state_d != StIdle) && ((state_d != state_q) || rearm);

        if (restart) begin
            phase_d = 1'b1;
        end else if (state_d != StIdle) begin
            cnt_d   = cnt_q + 1'b1;
            phase_d = phase_q;
            bcnt_d  = bcnt_q;
            if (cnt_q == CntLast) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
                toggle  = 1'b1;
                if (in_tap && phase_q) begin
                    bcnt_d = bcnt_q + 1'b1;
                    // Last lamp-on period done: drop straight to idle, lamps dark.
                    if (bcnt_d == BcntEnd) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                        phase_d = 1'b0;
                        bcnt_d  = '0;
                        toggle  = 1'b0;
                    end
                end
            end
        end

        left_lamp_d  = phase_d &&
                       ((state_d == StLeft) || (state_d == StTapL) || (state_d == StHazard));
        right_lamp_d = phase_d &&
                       ((state_d == StRight) || (state_d == StTapR) || (state_d == StHazard));

        // Exits to idle only ever turn lamps off, so they never raise click.
        click_d = toggle || (left_lamp_d && !left_lamp_q) || (right_lamp_d && !right_lamp_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            phase_q      <= 1'b0;
            bcnt_q       <= '0;
            left_lamp_q  <= 1'b0;
            right_lamp_q <= 1'b0;
            click_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            phase_q      <= phase_d;
            bcnt_q       <= bcnt_d;
            left_lamp_q  <= left_lamp_d;
            right_lamp_q <= right_lamp_d;
            click_q      <= click_d;
        end
    end

    assign left_lamp  = left_lamp_q;
    assign right_lamp = right_lamp_q;
    assign click      = click_q;
    assign mode       = state_q;

endmodule

// File: tb/tb_turn_signal_ctrl.sv
// Bench for turn_signal_ctrl: vector table, directed multi-cycle sequences and random
// stimulus against a time-since-entry reference model.
module tb_turn_signal_ctrl;

    localparam int H  = 4;
    localparam int TB = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       left = 1'b0, right = 1'b0, hazard = 1'b0, tap_left = 1'b0, tap_right = 1'b0;
    logic       left_lamp, right_lamp, click;
    logic [2:0] mode;

    int checks = 0;
    int errors = 0;

    // Reference model: mode plus cycles since entry; phase and tap end follow from t.
    int m_mode = 0;
    int m_t    = 0;
    bit m_ll   = 0;
    bit m_rl   = 0;
    bit m_clk  = 0;

    turn_signal_ctrl #(
        .BLINK_HALF(H),
        .TAP_BLINKS(TB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .left      (left),
        .right     (right),
        .hazard    (hazard),
        .tap_left  (tap_left),
        .tap_right (tap_right),
        .left_lamp (left_lamp),
        .right_lamp(right_lamp),
        .click     (click),
        .mode      (mode)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit l, r, h, tl, tr;
        bit ell, erl, eclk;
        int emode;
    } vec_t;

    function automatic bit is_active(input int m);
        return m != 0;
    endfunction

    function automatic bit is_tap(input int m);
        return (m == 5) || (m == 6);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_t = 0; m_ll = 0; m_rl = 0; m_clk = 0;
    endtask

    task automatic model_step(input bit l, input bit r, input bit h, input bit tl, input bit tr);
        int nm;
        bit rearm, restart, ph, nll, nrl, tog;
        rearm = 0;
        if (h) nm = 3;
        else if (l && r) nm = 0;
        else if (l) nm = 1;
        else if (r) nm = 2;
        else if (tl && !tr && (m_mode == 0 || is_tap(m_mode))) begin nm = 5; rearm = 1; end
        else if (tr && !tl && (m_mode == 0 || is_tap(m_mode))) begin nm = 6; rearm = 1; end
        else if (m_mode == 1 || m_mode == 2 || m_mode == 3) nm = 0;
        else nm = m_mode;
        restart = is_active(nm) && (nm != m_mode || rearm);
        if (!is_active(nm) || restart) m_t = 0;
        else m_t++;
        if (is_tap(nm) && !restart && m_t == (2 * TB - 1) * H) begin
            nm  = 0;
            m_t = 0;
        end
        ph   = is_active(nm) && ((m_t / H) % 2 == 0);
        nll  = ph && (nm == 1 || nm == 3 || nm == 5);
        nrl  = ph && (nm == 2 || nm == 3 || nm == 6);
        tog  = is_active(nm) && !restart && (m_t % H == 0);
        m_clk  = tog || (nll && !m_ll) || (nrl && !m_rl);
        m_ll   = nll;
        m_rl   = nrl;
        m_mode = nm;
    endtask

    task automatic step(input bit l, input bit r, input bit h, input bit tl, input bit tr);
        left = l; right = r; hazard = h; tap_left = tl; tap_right = tr;
        @(posedge clk);
        #1;
        model_step(l, r, h, tl, tr);
        check("model", {left_lamp, right_lamp, click, mode},
              {m_ll, m_rl, m_clk, 3'(m_mode)});
    endtask

    task automatic do_reset();
        rst = 1'b0;
        left = 0; right = 0; hazard = 0; tap_left = 0; tap_right = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
    endtask

    vec_t vecs[$];

    initial begin
        int n, on_cnt;
        bit l, r, h;

        // Scenario 2 and simultaneous-event corners, starting from idle.
        vecs.push_back('{1,0,0,0,0, 1,0,1, 1});
        vecs.push_back('{1,0,0,0,0, 1,0,0, 1});
        vecs.push_back('{1,0,0,0,0, 1,0,0, 1});
        vecs.push_back('{1,0,0,0,0, 1,0,0, 1});
        vecs.push_back('{1,0,0,0,0, 0,0,1, 1});
        vecs.push_back('{1,0,0,0,0, 0,0,0, 1});
        vecs.push_back('{0,0,0,0,0, 0,0,0, 0});
        vecs.push_back('{1,1,0,0,0, 0,0,0, 0});
        vecs.push_back('{0,0,0,1,1, 0,0,0, 0});
        vecs.push_back('{1,0,0,0,0, 1,0,1, 1});
        vecs.push_back('{1,0,0,1,0, 1,0,0, 1});
        vecs.push_back('{0,0,0,0,0, 0,0,0, 0});
        vecs.push_back('{0,0,0,0,1, 0,1,1, 6});
        vecs.push_back('{0,0,0,0,0, 0,1,0, 6});
        vecs.push_back('{1,0,0,0,0, 1,0,1, 1});
        vecs.push_back('{0,0,0,0,0, 0,0,0, 0});
        vecs.push_back('{0,0,1,0,0, 1,1,1, 3});
        vecs.push_back('{1,1,1,0,0, 1,1,0, 3});
        vecs.push_back('{0,0,0,0,0, 0,0,0, 0});

        #2;
        check("async_reset_lamps", {left_lamp, right_lamp, click, mode}, 0);
        do_reset();
        check("reset_state", {left_lamp, right_lamp, click, mode}, 0);

        foreach (vecs[i]) begin
            step(vecs[i].l, vecs[i].r, vecs[i].h, vecs[i].tl, vecs[i].tr);
            check($sformatf("vec%0d", i), {left_lamp, right_lamp, click, mode},
                  {vecs[i].ell, vecs[i].erl, vecs[i].eclk, 3'(vecs[i].emode)});
        end

        // Scenario 1: left held 20 cycles.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(1, 0, 0, 0, 0);
            check($sformatf("left_cadence%0d", i), {left_lamp, right_lamp, click, mode},
                  {((i / H) % 2 == 0), 1'b0, (i % H == 0), 3'd1});
        end

        // Scenario 3: tap_right, re-tap at cycle 6, then run to completion.
        do_reset();
        step(0, 0, 0, 0, 1);
        for (int i = 1; i < 6; i++) step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        check("retap_entry", {right_lamp, click, mode}, {1'b1, 1'b1, 3'd6});
        n = 1;
        on_cnt = right_lamp ? 1 : 0;
        while (mode != 0 && n < 40) begin
            step(0, 0, 0, 0, 0);
            if (mode != 0) n++;
            if (right_lamp) on_cnt++;
        end
        check("tap_duration", n, (2 * TB - 1) * H);
        check("tap_on_cycles", on_cnt, TB * H);
        step(0, 0, 0, 0, 0);
        check("tap_no_more_blinks", {left_lamp, right_lamp, click, mode}, 0);

        // Scenario 4: hazard over LEFT in its off phase, then release back to LEFT.
        do_reset();
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0);
        check("hazard_entry", {left_lamp, right_lamp, click, mode}, {1'b1, 1'b1, 1'b1, 3'd3});
        for (int i = 1; i < 10; i++) begin
            step(1, 0, 1, 0, 0);
            check($sformatf("hazard_sync%0d", i), {left_lamp, right_lamp},
                  {2{((i / H) % 2 == 0)}});
        end
        step(1, 0, 0, 0, 0);
        check("hazard_release", {left_lamp, right_lamp, mode}, {1'b1, 1'b0, 3'd1});

        // Scenario 5 tail: left during TAP_R.
        do_reset();
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check("left_preempts_tap", {left_lamp, right_lamp, mode}, {1'b1, 1'b0, 3'd1});

        // Scenario 6: asynchronous reset mid-blink in TAP_L.
        do_reset();
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check("tapl_before_reset", {left_lamp, mode}, {1'b0, 3'd5});
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check("tapl_lamp_on", {left_lamp, click, mode}, {1'b1, 1'b1, 3'd5});
        #2;
        rst = 1'b0;
        #1;
        check("async_reset_mid_blink", {left_lamp, right_lamp, click, mode}, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        step(0, 0, 0, 1, 0);
        n = 1;
        on_cnt = left_lamp ? 1 : 0;
        while (mode != 0 && n < 40) begin
            step(0, 0, 0, 0, 0);
            if (mode != 0) n++;
            if (left_lamp) on_cnt++;
        end
        check("post_reset_tap_duration", n, (2 * TB - 1) * H);
        check("post_reset_tap_on", on_cnt, TB * H);

        // Random stimulus with held levels, against the model every cycle.
        do_reset();
        l = 0; r = 0; h = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) l = ~l;
            if ($urandom_range(0, 15) == 0) r = ~r;
            if ($urandom_range(0, 40) == 0) h = ~h;
            step(l, r, h, ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
